// File: rtl/ibex_zkn_aes32_unit.sv
// rtl/ibex_zkn_aes32_unit.sv - AES32 (esi/esmi/dsi/dsmi) multi-cycle unit driving an external S-box
module ibex_zkn_aes32_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  op_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [7:0]  sbox_x_o,
    output logic        sbox_enc_dec_o,
    input  logic [7:0]  sbox_sx_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUB  = 2'b01,
        MIX  = 2'b10
    } state_e;

    state_e      state;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [1:0]  op_q;
    logic [1:0]  bs_q;
    logic [7:0]  s_q;

    logic [7:0]  s2, s4, s8;
    logic [31:0] col;
    logic [31:0] rot;
    logic [31:0] mix_result;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column coefficients are xtime chains of s: 3=2^1, 9=8^1, B=8^2^1, D=8^4^1, E=8^4^2.
    always_comb begin
        s2 = xtime(s_q);
        s4 = xtime(s2);
        s8 = xtime(s4);
        case (op_q)
            2'b01:   col = {s2 ^ s_q, s_q, s_q, s2};
            2'b11:   col = {s8 ^ s2 ^ s_q, s8 ^ s4 ^ s_q, s8 ^ s_q, s8 ^ s4 ^ s2};
            default: col = {24'h000000, s_q};
        endcase
        case (bs_q)
            2'd1:    rot = {col[23:0], col[31:24]};
            2'd2:    rot = {col[15:0], col[31:16]};
            2'd3:    rot = {col[7:0],  col[31:8]};
            default: rot = col;
        endcase
        mix_result = rot ^ rs1_q;
    end

    assign ready_o        = (state == IDLE) && !rst_i;
    assign sbox_x_o       = (state == SUB) ? rs2_q[{bs_q, 3'b000} +: 8] : 8'h00;
    assign sbox_enc_dec_o = (state == SUB) ? ~op_q[1] : 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            result_o <= 32'h0;
            rs1_q    <= 32'h0;
            rs2_q    <= 32'h0;
            op_q     <= 2'b00;
            bs_q     <= 2'b00;
            s_q      <= 8'h00;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && !kill_i) begin
                        rs1_q <= rs1_i;
                        rs2_q <= rs2_i;
                        op_q  <= op_i;
                        bs_q  <= bs_i;
                        state <= SUB;
                    end
                end
                SUB: begin
                    if (kill_i) begin
                        state <= IDLE;
                    end else begin
                        s_q   <= sbox_sx_i;
                        state <= MIX;
                    end
                end
                MIX: begin
                    if (!kill_i) begin
                        result_o <= mix_result;
                        valid_o  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
